// File: rtl/tmr_vote_stage.sv
// Registered TMR majority-vote stage with valid/ready output register, mismatch
// flags, saturating error counter and per-lane fault tracking. Optional parity
// path enabled by defining TMR_VOTE_STAGE_PARITY_EN.
//
// Lane FSM states (one instance per lane):
//   state      | meaning
//   ST_OK      | lane agreed with the vote on the last accepted word
//   ST_SUSPECT | lane has mismatched on r_streak consecutive accepted words
//   ST_FAULT   | lane hit FAULT_THRESH consecutive mismatches; sticky until clr/rst
module tmr_vote_stage #(
  parameter int WIDTH        = 2,
  parameter int CNT_W        = 8,
  parameter int FAULT_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_a,
  input  logic [WIDTH-1:0] d_b,
  input  logic [WIDTH-1:0] d_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       mism,
  output logic             multi_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2:0]       fault,
`ifdef TMR_VOTE_STAGE_PARITY_EN
  input  logic             in_par,
  output logic             out_par,
  output logic             par_err,
`endif
  input  logic             clr
);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } lane_st_t;

  localparam logic [3:0] LP_THRESH = 4'(FAULT_THRESH);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [2:0]       r_mism;
  logic             r_multi_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0] w_lane [3];
  logic [WIDTH-1:0] w_vote;
  logic [2:0]       w_mism;
  logic             w_multi;
  logic             w_accept;
  logic             w_any_err;
  logic [CNT_W-1:0] w_err_cnt_nxt;

  lane_st_t         r_lane_st     [3];
  lane_st_t         w_lane_st_nxt [3];
  logic [3:0]       r_streak      [3];
  logic [3:0]       w_streak_nxt  [3];

  assign w_lane[0] = d_a;
  assign w_lane[1] = d_b;
  assign w_lane[2] = d_c;

  assign w_vote = (d_a & d_b) | (d_a & d_c) | (d_b & d_c);

  always_comb begin
    w_mism = '0;
    for (int k = 0; k < 3; k++) begin
      w_mism[k] = |(w_lane[k] ^ w_vote);
    end
  end

  assign w_multi  = (w_mism[0] & w_mism[1]) | (w_mism[0] & w_mism[2]) | (w_mism[1] & w_mism[2]);
  assign in_ready = !r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

`ifdef TMR_VOTE_STAGE_PARITY_EN
  logic r_out_par;
  logic r_par_err;
  logic w_par_err;

  assign w_par_err = in_par ^ (^w_vote);
  assign w_any_err = (|w_mism) | w_par_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_par <= 1'b0;
      r_par_err <= 1'b0;
    end else if (w_accept) begin
      r_out_par <= ^w_vote;
      r_par_err <= w_par_err;
    end
  end

  assign out_par = r_out_par;
  assign par_err = r_par_err;
`else
  assign w_any_err = |w_mism;
`endif

  // Output register: accept loads, a transfer alone only drops valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_mism      <= '0;
      r_multi_err <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_vote;
      r_mism      <= w_mism;
      r_multi_err <= w_multi;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_comb begin
    w_err_cnt_nxt = r_err_cnt;
    if (clr) begin
      w_err_cnt_nxt = '0;
    end else if (w_accept && w_any_err && (r_err_cnt != {CNT_W{1'b1}})) begin
      w_err_cnt_nxt = r_err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else begin
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        r_lane_st[k] <= ST_OK;
        r_streak[k]  <= 4'd0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        r_lane_st[k] <= w_lane_st_nxt[k];
        r_streak[k]  <= w_streak_nxt[k];
      end
    end
  end

  // clr has priority over an accept in the same cycle.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_lane_st_nxt[k] = r_lane_st[k];
      w_streak_nxt[k]  = r_streak[k];
      if (clr) begin
        w_lane_st_nxt[k] = ST_OK;
        w_streak_nxt[k]  = 4'd0;
      end else if (w_accept) begin
        case (r_lane_st[k])
          ST_OK: begin
            if (w_mism[k]) begin
              w_streak_nxt[k]  = 4'd1;
              w_lane_st_nxt[k] = (LP_THRESH == 4'd1) ? ST_FAULT : ST_SUSPECT;
            end
          end
          ST_SUSPECT: begin
            if (w_mism[k]) begin
              w_streak_nxt[k] = r_streak[k] + 4'd1;
              if ((r_streak[k] + 4'd1) >= LP_THRESH) begin
                w_lane_st_nxt[k] = ST_FAULT;
              end
            end else begin
              w_streak_nxt[k]  = 4'd0;
              w_lane_st_nxt[k] = ST_OK;
            end
          end
          ST_FAULT: begin
            w_lane_st_nxt[k] = ST_FAULT;
          end
          default: begin
            w_lane_st_nxt[k] = ST_OK;
            w_streak_nxt[k]  = 4'd0;
          end
        endcase
      end
    end
  end

  always_comb begin
    fault = '0;
    for (int k = 0; k < 3; k++) begin
      fault[k] = (r_lane_st[k] == ST_FAULT);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign mism      = r_mism;
  assign multi_err = r_multi_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_tmr_vote_stage.sv
// Directed self-checking bench for tmr_vote_stage; covers the parity path when
// TMR_VOTE_STAGE_PARITY_EN is defined.
module tb_tmr_vote_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] d_a, d_b, d_c;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic [2:0] mism;
  logic       multi_err;
  logic [7:0] err_cnt;
  logic [2:0] fault;
  logic       clr;
`ifdef TMR_VOTE_STAGE_PARITY_EN
  logic       in_par;
  logic       out_par;
  logic       par_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tmr_vote_stage #(.WIDTH(2), .CNT_W(8), .FAULT_THRESH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_a       (d_a),
    .d_b       (d_b),
    .d_c       (d_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .mism      (mism),
    .multi_err (multi_err),
    .err_cnt   (err_cnt),
    .fault     (fault),
`ifdef TMR_VOTE_STAGE_PARITY_EN
    .in_par    (in_par),
    .out_par   (out_par),
    .par_err   (par_err),
`endif
    .clr       (clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    in_valid = v;
    d_a = a;
    d_b = b;
    d_c = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 2'b00, 2'b00);
`ifdef TMR_VOTE_STAGE_PARITY_EN
    in_par = 1'b0;
`endif
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    rst = 1'b0;

    // clean word
    drive(1'b1, 2'b10, 2'b10, 2'b10);
    tick();
    check("clean_valid", 32'(out_valid), 32'd1);
    check("clean_data", 32'(out_data), 32'b10);
    check("clean_mism", 32'(mism), 32'b000);
    check("clean_cnt", 32'(err_cnt), 32'd0);

    // lane A single-bit error
    drive(1'b1, 2'b11, 2'b10, 2'b10);
    tick();
    check("a_err_data", 32'(out_data), 32'b10);
    check("a_err_mism", 32'(mism), 32'b001);
    check("a_err_multi", 32'(multi_err), 32'd0);
    check("a_err_cnt", 32'(err_cnt), 32'd1);

    // A and B corrupted in different bits
    drive(1'b1, 2'b01, 2'b10, 2'b00);
    tick();
    check("multi_data", 32'(out_data), 32'b00);
    check("multi_mism", 32'(mism), 32'b011);
    check("multi_flag", 32'(multi_err), 32'd1);
    check("multi_cnt", 32'(err_cnt), 32'd2);

    // lane C three consecutive mismatches
    drive(1'b1, 2'b10, 2'b10, 2'b11);
    tick();
    check("c1_fault", 32'(fault), 32'b000);
    check("c1_cnt", 32'(err_cnt), 32'd3);
    tick();
    check("c2_fault", 32'(fault), 32'b000);
    tick();
    check("c3_fault", 32'(fault), 32'b100);
    check("c3_cnt", 32'(err_cnt), 32'd5);
    check("c3_mism", 32'(mism), 32'b100);

    // clr alone; transfer without accept holds data
    drive(1'b0, 2'b00, 2'b00, 2'b00);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_fault", 32'(fault), 32'b000);
    check("clr_cnt", 32'(err_cnt), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data_hold", 32'(out_data), 32'b10);
    check("drain_mism_hold", 32'(mism), 32'b100);

    // corrupt, clean, corrupt, corrupt on lane C: streak broken
    drive(1'b1, 2'b01, 2'b01, 2'b00);
    tick();
    drive(1'b1, 2'b01, 2'b01, 2'b01);
    tick();
    drive(1'b1, 2'b01, 2'b01, 2'b00);
    tick();
    tick();
    check("broken_fault", 32'(fault), 32'b000);
    check("broken_cnt", 32'(err_cnt), 32'd3);

    // clr coinciding with a mismatching accept
    drive(1'b1, 2'b01, 2'b00, 2'b00);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clracc_cnt", 32'(err_cnt), 32'd0);
    check("clracc_mism", 32'(mism), 32'b001);
    check("clracc_data", 32'(out_data), 32'b00);
    check("clracc_valid", 32'(out_valid), 32'd1);

    // stall for 4 cycles
    drive(1'b1, 2'b11, 2'b11, 2'b11);
    tick();
    check("stall_load", 32'(out_data), 32'b11);
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 2'b00, 2'b00);
    #1;
    check("stall_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_data", 32'(out_data), 32'b11);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_rdy", 32'(in_ready), 32'd0);
    end
    check("stall_cnt", 32'(err_cnt), 32'd0);
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 2'b01, 2'b01);
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("b2b_1_data", 32'(out_data), 32'b01);
    check("b2b_1_valid", 32'(out_valid), 32'd1);
    drive(1'b1, 2'b10, 2'b10, 2'b10);
    tick();
    check("b2b_2_data", 32'(out_data), 32'b10);
    check("b2b_2_valid", 32'(out_valid), 32'd1);

    // saturation: 300 mismatching words on lane A
    drive(1'b1, 2'b11, 2'b00, 2'b00);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) check("sat_254", 32'(err_cnt), 32'd254);
      if (i == 255) check("sat_255", 32'(err_cnt), 32'd255);
    end
    check("sat_300", 32'(err_cnt), 32'd255);
    check("sat_fault", 32'(fault), 32'b001);

`ifdef TMR_VOTE_STAGE_PARITY_EN
    clr = 1'b1;
    drive(1'b0, 2'b00, 2'b00, 2'b00);
    tick();
    clr = 1'b0;
    in_par = 1'b1;
    drive(1'b1, 2'b11, 2'b11, 2'b11);
    tick();
    check("par_err_set", 32'(par_err), 32'd1);
    check("par_out", 32'(out_par), 32'd0);
    check("par_cnt", 32'(err_cnt), 32'd1);
    check("par_mism", 32'(mism), 32'b000);
    in_par = 1'b0;
    drive(1'b1, 2'b01, 2'b01, 2'b11);
    tick();
    check("par_both_err", 32'(par_err), 32'd1);
    check("par_both_out", 32'(out_par), 32'd1);
    check("par_both_cnt", 32'(err_cnt), 32'd2);
    in_par = 1'b1;
    tick();
    check("par_ok", 32'(par_err), 32'd0);
    check("par_ok_cnt", 32'(err_cnt), 32'd3);
`endif

    // reset asserted in the middle of a stall
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 2'b00, 2'b01);
    tick();
    drive(1'b0, 2'b00, 2'b00, 2'b00);
    check("prerst_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_cnt", 32'(err_cnt), 32'd0);
    check("midrst_fault", 32'(fault), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
`ifdef TMR_VOTE_STAGE_PARITY_EN
    check("midrst_par_err", 32'(par_err), 32'd0);
`endif
    #2;
    rst = 1'b0;
    tick();
    check("postrst_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmr_vote_stage.md
Name: tmr_vote_stage

Overview:
- Registered majority-voting stage directly upstream of the non-triplicated concat consumer.
- Takes three redundant copies of a WIDTH-bit word, votes bitwise, and presents one corrected word through a valid/ready handshake.
- Flags which lanes disagreed and counts errors.
- Tracks per-lane persistent faults, so a lane that keeps disagreeing is reported as failed.

Parameters:
- WIDTH, 2, data width per lane; matches the 2-bit operand width of the consumer.
- CNT_W, 8, width of the saturating error counter.
- FAULT_THRESH, 3, consecutive mismatching accepted words before a lane is declared faulty; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  the three lane words are valid.
- in_ready  output  1  stage can accept a word this cycle.
- d_a  input  WIDTH  lane A copy.
- d_b  input  WIDTH  lane B copy.
- d_c  input  WIDTH  lane C copy.
- out_valid  output  1  out_data holds a voted word.
- out_ready  input  1  consumer takes the word.
- out_data  output  WIDTH  bitwise majority of the accepted lanes.
- mism  output  3  per lane [A,B,C] = [0,1,2], registered with out_data; lane differed from the vote.
- multi_err  output  1  registered with out_data; two or more lanes flagged in the same word.
- err_cnt  output  CNT_W  saturating count of accepted words with any mism bit set.
- fault  output  3  sticky per-lane fault flags.
- clr  input  1  synchronous clear of err_cnt, fault and the lane streak state.

Behaviour:
- Reset values (asynchronous on rst high):
  - out_valid=0, out_data=0, mism=0, multi_err=0, err_cnt=0, fault=0.
  - All lane FSMs in OK.
  - in_ready goes high immediately, since it is combinational and out_valid=0.
- Handshake:
  - in_ready = !out_valid | out_ready. This is a one-entry output register with full throughput.
  - Accept = in_valid & in_ready.
  - Transfer = out_valid & out_ready.
  - On accept: out_valid<=1, and out_data, mism and multi_err load in the same edge. Latency is 1 cycle.
  - On transfer without accept: out_valid<=0, and data fields hold their value.
  - Simultaneous transfer and accept: the new word replaces the old one, out_valid stays 1, and there is no bubble.
  - While out_valid=1 and out_ready=0, all outputs hold stable. Inputs are ignored (in_ready=0).
- Vote:
  - Per bit, v = (a&b)|(a&c)|(b&c).
  - mism[k] = |(lane_k ^ v).
  - multi_err = popcount(mism) >= 2. With three lanes this means different bits were corrupted in different lanes; each bit is still voted independently.
- Error counter:
  - +1 on each accept with any mism bit set.
  - Holds at 2^CNT_W-1 with no wrap.
- Lane FSM, one per lane, advancing only on accept:
  - OK: if the lane mismatches, go to SUSPECT with streak=1. If FAULT_THRESH=1, go directly to FAULT.
  - SUSPECT: if it mismatches, streak+1; when streak reaches FAULT_THRESH, go to FAULT. If it matches, return to OK and streak=0.
  - FAULT: sticky. fault[k]=1. Leaves only on clr or rst.
- clr:
  - err_cnt<=0, fault<=0, and all FSMs go to OK.
  - If clr coincides with an accept, clr wins for the counters and FSMs. That word is not counted, but its data, mism and multi_err are still registered and presented.
  - clr does not affect out_valid or out_data.
- Reset mid-transfer: the pending word is discarded, with no output glitch beyond out_valid dropping asynchronously.

Optional Feature:
- Macro: TMR_VOTE_STAGE_PARITY_EN.
- When defined:
  - Adds output out_par, 1 bit, = ^vote, registered alongside out_data; reset value 0.
  - Adds input in_par, 1 bit, the expected parity of the lanes, and output par_err, 1 bit, registered on accept = in_par ^ (^vote); reset value 0.
  - A par_err word also increments err_cnt, once per word even if mism is also set.
- When undefined: out_par, in_par and par_err are absent. err_cnt counts mism words only.

Test Plan:
- Reset, then d_a=d_b=d_c=2'b10 with in_valid=1 -> next cycle out_valid=1, out_data=2'b10, mism=000, err_cnt=0.
- d_a=2'b11, d_b=2'b10, d_c=2'b10 -> out_data=2'b10, mism=001, multi_err=0, err_cnt=1.
- d_a=2'b01, d_b=2'b10, d_c=2'b00 -> out_data=2'b00, mism=011, multi_err=1, err_cnt increments by 1.
- Lane C corrupted on 3 consecutive accepts (FAULT_THRESH=3) -> fault=100 after the third accept.
  - The pattern corrupt, clean, corrupt, corrupt leaves fault=000.
  - Assert clr -> fault=000 and err_cnt=0 the next cycle.
- out_ready=0 for 4 cycles while in_valid=1 -> in_ready=0 and out_data stable. Then out_ready=1 with a new word -> back-to-back transfer with no bubble. Also check 300 mismatching words -> err_cnt saturates at 255.
- Macro defined, lanes 2'b11 with in_par=1 -> par_err=1 (computed parity 0) and err_cnt+1. Assert rst mid-stall -> out_valid=0 immediately.
